// File: rtl/regex_thread_scheduler_pkg.sv
// Shared types for the regex thread scheduler.
// Holds the FSM encoding and the queue routing helper.
package scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    FLUSH,
    DONE
  } sched_state_t;

  function automatic logic tgt_idx(
    input logic sel,
    input logic to_cur
  );
    return to_cur ? sel : ~sel;
  endfunction

endpackage

// File: rtl/regex_thread_scheduler_if.sv
// String stream and core handshakes of the scheduler.
// master = scheduler side, slave = loader/core side.
interface regex_thread_scheduler_if #(
  parameter int PC_WIDTH        = 8,
  parameter int CHARACTER_WIDTH = 8
);
  logic                       char_valid;
  logic [CHARACTER_WIDTH-1:0] char_data;
  logic                       char_ready;
  logic [CHARACTER_WIDTH-1:0] current_character;
  logic                       cpu_input_pc_valid;
  logic [PC_WIDTH-1:0]        cpu_input_pc;
  logic                       cpu_input_pc_ready;
  logic                       cpu_output_pc_valid;
  logic [PC_WIDTH-1:0]        cpu_output_pc;
  logic                       cpu_output_pc_is_directed_to_current;
  logic                       cpu_output_pc_ready;
  logic                       cpu_accepts;
  logic                       cpu_running;

  modport master (
    input  char_valid,
    input  char_data,
    output char_ready,
    output current_character,
    output cpu_input_pc_valid,
    output cpu_input_pc,
    input  cpu_input_pc_ready,
    input  cpu_output_pc_valid,
    input  cpu_output_pc,
    input  cpu_output_pc_is_directed_to_current,
    output cpu_output_pc_ready,
    input  cpu_accepts,
    input  cpu_running
  );

  modport slave (
    output char_valid,
    output char_data,
    input  char_ready,
    input  current_character,
    input  cpu_input_pc_valid,
    input  cpu_input_pc,
    output cpu_input_pc_ready,
    output cpu_output_pc_valid,
    output cpu_output_pc,
    output cpu_output_pc_is_directed_to_current,
    input  cpu_output_pc_ready,
    output cpu_accepts,
    output cpu_running
  );

endinterface

// File: rtl/regex_thread_scheduler_fifo.sv
// Show-ahead PC queue with occupancy count and clear.
// Push is ignored when full, pop when empty; clear wins.
module fifo #(
  parameter int DWIDTH      = 8,
  parameter int COUNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 push,
  input  logic [DWIDTH-1:0]    din,
  input  logic                 pop,
  output logic [DWIDTH-1:0]    dout,
  output logic                 empty,
  output logic [COUNT_WIDTH:0] count
);

  localparam int DEPTH = 2 ** COUNT_WIDTH;
  localparam logic [COUNT_WIDTH:0] FULL_CNT =
    (COUNT_WIDTH + 1)'(DEPTH);

  logic [DWIDTH-1:0]      mem_q [DEPTH];
  logic [DWIDTH-1:0]      mem_d [DEPTH];
  logic [COUNT_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [COUNT_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [COUNT_WIDTH:0]   cnt_q, cnt_d;
  logic                   do_push, do_pop;

  assign empty   = cnt_q == '0;
  assign count   = cnt_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && (cnt_q != FULL_CNT);
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      cnt_d = cnt_q
            + {{COUNT_WIDTH{1'b0}}, do_push}
            - {{COUNT_WIDTH{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/regex_thread_scheduler.sv
// Drives one regex core over a string with two PC queues.
// Q[sel] feeds the core this character, Q[~sel] collects next.
module regex_thread_scheduler
  import scheduler_pkg::*;
#(
  parameter int PC_WIDTH        = 8,
  parameter int CHARACTER_WIDTH = 8,
  parameter int QUEUE_CNT_WIDTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [PC_WIDTH-1:0] start_pc,
  regex_thread_scheduler_if.master bus,
  output logic                busy,
  output logic                done,
  output logic                accepted
);

  localparam logic [QUEUE_CNT_WIDTH:0] Q_FULL =
    (QUEUE_CNT_WIDTH + 1)'(2 ** QUEUE_CNT_WIDTH);

  sched_state_t               state_q, state_d;
  logic                       sel_q, sel_d;
  logic [CHARACTER_WIDTH-1:0] char_q, char_d;
  logic                       acc_q, acc_d;
  logic                       disp_prev_q, disp_prev_d;

  logic [1:0]                 q_push, q_pop;
  logic [1:0]                 q_empty, q_full;
  logic                       q_clear;
  logic [PC_WIDTH-1:0]        push_pc;
  logic [PC_WIDTH-1:0]        q_head [2];
  logic [QUEUE_CNT_WIDTH:0]   q_cnt  [2];

  logic cur_empty, nxt_empty, tgt;
  logic disp, out_hs, quiescent;

  fifo #(
    .DWIDTH     (PC_WIDTH),
    .COUNT_WIDTH(QUEUE_CNT_WIDTH)
  ) u_q0 (
    .clk  (clk),
    .reset(reset),
    .clear(q_clear),
    .push (q_push[0]),
    .din  (push_pc),
    .pop  (q_pop[0]),
    .dout (q_head[0]),
    .empty(q_empty[0]),
    .count(q_cnt[0])
  );

  fifo #(
    .DWIDTH     (PC_WIDTH),
    .COUNT_WIDTH(QUEUE_CNT_WIDTH)
  ) u_q1 (
    .clk  (clk),
    .reset(reset),
    .clear(q_clear),
    .push (q_push[1]),
    .din  (push_pc),
    .pop  (q_pop[1]),
    .dout (q_head[1]),
    .empty(q_empty[1]),
    .count(q_cnt[1])
  );

  assign q_full[0] = q_cnt[0] == Q_FULL;
  assign q_full[1] = q_cnt[1] == Q_FULL;
  assign cur_empty = q_empty[sel_q];
  assign nxt_empty = q_empty[~sel_q];
  assign tgt = tgt_idx(sel_q,
    bus.cpu_output_pc_is_directed_to_current);

  assign disp = (state_q == RUN) && !cur_empty
             && bus.cpu_input_pc_ready;
  assign out_hs = (state_q == RUN)
               && bus.cpu_output_pc_valid
               && !q_full[tgt];

  // disp_prev_q covers the cycle before the core raises running
  assign quiescent = cur_empty
                  && !bus.cpu_running
                  && !bus.cpu_output_pc_valid
                  && !disp && !disp_prev_q;

  assign bus.current_character = char_q;
  assign busy     = state_q != IDLE;
  assign done     = state_q == DONE;
  assign accepted = acc_q;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    char_d      = char_q;
    acc_d       = acc_q;
    disp_prev_d = 1'b0;
    q_push      = '0;
    q_pop       = '0;
    q_clear     = 1'b0;
    push_pc     = bus.cpu_output_pc;
    bus.char_ready          = 1'b0;
    bus.cpu_input_pc_valid  = 1'b0;
    bus.cpu_input_pc        = '0;
    bus.cpu_output_pc_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          q_push[sel_q] = 1'b1;
          push_pc       = start_pc;
          acc_d         = 1'b0;
          state_d       = LOAD;
        end
      end
      LOAD: begin
        bus.char_ready = 1'b1;
        if (bus.char_valid) begin
          char_d  = bus.char_data;
          state_d = RUN;
        end
      end
      RUN: begin
        bus.cpu_input_pc_valid  = !cur_empty;
        bus.cpu_input_pc        = q_head[sel_q];
        bus.cpu_output_pc_ready = !q_full[tgt];
        q_pop[sel_q] = disp;
        q_push[tgt]  = out_hs;
        disp_prev_d  = disp;
        if (bus.cpu_accepts) begin
          acc_d   = 1'b1;
          state_d = FLUSH;
        end else if (quiescent) begin
          if (char_q == '0 || nxt_empty) begin
            q_clear = 1'b1;
            state_d = DONE;
          end else begin
            sel_d   = ~sel_q;
            state_d = LOAD;
          end
        end
      end
      FLUSH: begin
        bus.cpu_output_pc_ready = 1'b1;
        if (!bus.cpu_running && !bus.cpu_output_pc_valid) begin
          q_clear = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      char_q      <= '0;
      acc_q       <= 1'b0;
      disp_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      char_q      <= char_d;
      acc_q       <= acc_d;
      disp_prev_q <= disp_prev_d;
    end
  end

endmodule

// File: tb/tb_regex_thread_scheduler.sv
// Directed bench for regex_thread_scheduler.
// The bench plays string loader and regex core by hand.
module tb_regex_thread_scheduler;

  localparam int PW = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [PW-1:0] start_pc;
  logic          busy, done, accepted;

  int tests = 0;
  int fails = 0;
  int nchar = 0;
  bit saw_ready;

  regex_thread_scheduler_if #(
    .PC_WIDTH(PW), .CHARACTER_WIDTH(CW)
  ) bus ();

  regex_thread_scheduler #(
    .PC_WIDTH(PW), .CHARACTER_WIDTH(CW),
    .QUEUE_CNT_WIDTH(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .start_pc(start_pc),
    .bus     (bus),
    .busy    (busy),
    .done    (done),
    .accepted(accepted)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [PW-1:0] pc);
    start    = 1'b1;
    start_pc = pc;
    step();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("acc_cleared", accepted, 0);
  endtask

  task automatic load_char(input logic [CW-1:0] c);
    int n = 0;
    while (bus.char_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("load_ready", bus.char_ready, 1);
    bus.char_valid = 1'b1;
    bus.char_data  = c;
    step();
    bus.char_valid = 1'b0;
    nchar++;
    chk("cur_char", bus.current_character, c);
  endtask

  task automatic dispatch(input logic [PW-1:0] pc);
    int n = 0;
    while (bus.cpu_input_pc_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("disp_valid", bus.cpu_input_pc_valid, 1);
    chk("disp_pc", bus.cpu_input_pc, pc);
    bus.cpu_input_pc_ready = 1'b1;
    step();
    bus.cpu_input_pc_ready = 1'b0;
  endtask

  task automatic emit(input logic [PW-1:0] pc,
                      input logic to_cur);
    int n = 0;
    bus.cpu_output_pc_valid = 1'b1;
    bus.cpu_output_pc       = pc;
    bus.cpu_output_pc_is_directed_to_current = to_cur;
    #1;
    while (bus.cpu_output_pc_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("emit_ready", bus.cpu_output_pc_ready, 1);
    step();
    bus.cpu_output_pc_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    saw_ready = 1'b0;
    while (done !== 1'b1 && n < 50) begin
      if (bus.char_ready === 1'b1) saw_ready = 1'b1;
      step();
      n++;
    end
    chk("done_high", done, 1);
    step();
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int idx, got, n;
    bit full_seen, ph, dh;
    reset    = 1'b1;
    start    = 1'b0;
    start_pc = '0;
    bus.char_valid          = 1'b0;
    bus.char_data           = '0;
    bus.cpu_input_pc_ready  = 1'b0;
    bus.cpu_output_pc_valid = 1'b0;
    bus.cpu_output_pc       = '0;
    bus.cpu_output_pc_is_directed_to_current = 1'b0;
    bus.cpu_accepts         = 1'b0;
    bus.cpu_running         = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_acc", accepted, 0);
    chk("rst_char_ready", bus.char_ready, 0);
    chk("rst_in_valid", bus.cpu_input_pc_valid, 0);
    chk("rst_in_pc", bus.cpu_input_pc, 0);
    chk("rst_out_ready", bus.cpu_output_pc_ready, 0);
    chk("rst_cur_char", bus.current_character, 0);

    // literal "ab" accepted; start during LOAD ignored
    start_run(8'h00);
    nchar    = 0;
    start    = 1'b1;
    start_pc = 8'h55;
    load_char("a");
    start = 1'b0;
    dispatch(8'h00);
    bus.cpu_running = 1'b1;
    emit(8'h01, 1'b0);
    bus.cpu_running = 1'b0;
    load_char("b");
    dispatch(8'h01);
    bus.cpu_running = 1'b1;
    emit(8'h02, 1'b0);
    bus.cpu_running = 1'b0;
    load_char(8'h00);
    dispatch(8'h02);
    bus.cpu_running = 1'b1;
    bus.cpu_accepts = 1'b1;
    step();
    bus.cpu_accepts = 1'b0;
    bus.cpu_running = 1'b0;
    chk("ab_acc_flush", accepted, 1);
    chk("ab_busy_flush", busy, 1);
    wait_done();
    chk("ab_nchar", nchar, 3);
    chk("ab_acc", accepted, 1);
    step();
    chk("ab_acc_held", accepted, 1);

    // mismatch "ac": reject without fetching terminator
    start_run(8'h00);
    nchar = 0;
    load_char("a");
    dispatch(8'h00);
    bus.cpu_running = 1'b1;
    emit(8'h01, 1'b0);
    bus.cpu_running = 1'b0;
    load_char("c");
    dispatch(8'h01);
    bus.cpu_running = 1'b1;
    step();
    bus.cpu_running = 1'b0;
    wait_done();
    chk("mm_no_fetch", saw_ready, 0);
    chk("mm_nchar", nchar, 2);
    chk("mm_acc", accepted, 0);

    // fan-out of 20 current-directed PCs
    start_run(8'h05);
    load_char("x");
    dispatch(8'h05);
    bus.cpu_running = 1'b1;
    idx = 0;
    got = 0;
    n   = 0;
    full_seen = 1'b0;
    while (got < 20 && n < 200) begin
      bus.cpu_output_pc_valid = idx < 20;
      bus.cpu_output_pc       = 8'(10 + idx);
      bus.cpu_output_pc_is_directed_to_current = 1'b1;
      #1;
      if (!full_seen && idx == 16) begin
        chk("fan_full_ready", bus.cpu_output_pc_ready, 0);
        full_seen = 1'b1;
        bus.cpu_input_pc_ready = 1'b1;
        #1;
      end
      ph = bus.cpu_output_pc_valid && bus.cpu_output_pc_ready;
      dh = bus.cpu_input_pc_valid && bus.cpu_input_pc_ready;
      if (dh) chk("fan_pc", bus.cpu_input_pc, 10 + got);
      step();
      if (ph) idx++;
      if (dh) got++;
      n++;
    end
    bus.cpu_output_pc_valid = 1'b0;
    bus.cpu_input_pc_ready  = 1'b0;
    bus.cpu_running         = 1'b0;
    chk("fan_got", got, 20);
    chk("fan_pushed", idx, 20);
    wait_done();
    chk("fan_acc", accepted, 0);

    // accept at char 2 of "pqrst"
    start_run(8'h00);
    nchar = 0;
    load_char("p");
    dispatch(8'h00);
    bus.cpu_running = 1'b1;
    emit(8'h01, 1'b0);
    bus.cpu_running = 1'b0;
    load_char("q");
    dispatch(8'h01);
    bus.cpu_running = 1'b1;
    emit(8'h02, 1'b0);
    bus.cpu_running = 1'b0;
    load_char("r");
    dispatch(8'h02);
    bus.cpu_running = 1'b1;
    emit(8'h09, 1'b0);
    bus.cpu_accepts         = 1'b1;
    bus.cpu_output_pc_valid = 1'b1;
    bus.cpu_output_pc       = 8'h07;
    bus.cpu_output_pc_is_directed_to_current = 1'b1;
    step();
    bus.cpu_accepts   = 1'b0;
    bus.cpu_output_pc = 8'h08;
    #1;
    chk("fl_out_ready", bus.cpu_output_pc_ready, 1);
    chk("fl_no_disp", bus.cpu_input_pc_valid, 0);
    step();
    bus.cpu_output_pc_valid = 1'b0;
    bus.cpu_running         = 1'b0;
    wait_done();
    chk("fl_no_fetch", saw_ready, 0);
    chk("fl_nchar", nchar, 3);
    chk("fl_acc", accepted, 1);
    chk("fl_q0_empty", dut.q_cnt[0], 0);
    chk("fl_q1_empty", dut.q_cnt[1], 0);

    // running raised one cycle after dispatch
    start_run(8'h03);
    load_char("k");
    dispatch(8'h03);
    step();
    chk("gap_busy", busy, 1);
    chk("gap_done", done, 0);
    chk("gap_load", bus.char_ready, 0);
    bus.cpu_running = 1'b1;
    step();
    chk("gap_load2", bus.char_ready, 0);
    emit(8'h04, 1'b0);
    bus.cpu_running = 1'b0;
    load_char("m");
    dispatch(8'h04);
    bus.cpu_running = 1'b1;
    step();
    bus.cpu_running = 1'b0;
    wait_done();
    chk("gap_acc", accepted, 0);

    // reset in RUN with both queues occupied
    start_run(8'h20);
    load_char("a");
    dispatch(8'h20);
    bus.cpu_running = 1'b1;
    emit(8'h21, 1'b0);
    emit(8'h22, 1'b1);
    chk("pre_rst_q0", dut.q_cnt[0], 1);
    chk("pre_rst_q1", dut.q_cnt[1], 1);
    bus.cpu_output_pc_valid = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.cpu_output_pc_valid = 1'b0;
    bus.cpu_running         = 1'b0;
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_q0", dut.q_cnt[0], 0);
    chk("mr_q1", dut.q_cnt[1], 0);
    chk("mr_in_valid", bus.cpu_input_pc_valid, 0);
    chk("mr_char_ready", bus.char_ready, 0);
    chk("mr_cur_char", bus.current_character, 0);
    chk("mr_acc", accepted, 0);
    start_run(8'h30);
    load_char("z");
    dispatch(8'h30);
    bus.cpu_running = 1'b1;
    step();
    bus.cpu_running = 1'b0;
    wait_done();
    chk("mr_rerun_acc", accepted, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
